cache_axi_bridge: RTL and testbench

CACHE_AXI_BRIDGE -- requirements
Module: cache_axi_bridge

---
 rtl/cache_axi_pkg.sv | 25 ++
 rtl/axi_line_writer.sv | 106 ++++++++++
 rtl/cache_axi_bridge.sv | 152 +++++++++++++++
 tb/tb_cache_axi_bridge.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_axi_pkg.sv
// Shared types and AXI burst constants for the cache-to-AXI bridge.
// A cache line is 128 bits, moved as a 4-beat INCR burst of 32-bit words.
package cache_axi_pkg;

  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_4B    = 3'd2;
  localparam logic [7:0] LINE_LEN   = 8'd3;
  localparam int         LINE_BEATS = 4;

  typedef enum logic [1:0] {
    R_IDLE,
    R_ADDR,
    R_DATA,
    R_DONE
  } rd_state_t;

  typedef enum logic [2:0] {
    W_IDLE,
    W_ADDR,
    W_DATA,
    W_RESP,
    W_DONE
  } wr_state_t;

endpackage

// File: rtl/axi_line_writer.sv
// Write-back engine: accepts one 128-bit line and emits it as an AW + 4-beat W
// burst, then waits for the B response before pulsing wr_valid.
module axi_line_writer
  import cache_axi_pkg::*;
#(
  parameter logic [3:0] WR_ID = 4'd1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         wr_req,
  input  logic [31:0]  wr_addr,
  input  logic [127:0] wr_data,
  output logic         wr_rdy,
  output logic         wr_valid,
  output logic         busy,
  output logic [27:0]  line,
  output logic [3:0]   awid,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic         awvalid,
  input  logic         awready,
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic [3:0]   bid,
  input  logic [1:0]   bresp,
  input  logic         bvalid,
  output logic         bready
);

  wr_state_t    state, state_nxt;
  logic [1:0]   beat;
  logic [127:0] line_data;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= W_IDLE;
      beat  <= 2'd0;
    end else begin
      state <= state_nxt;
      if (state == W_IDLE)
        beat <= 2'd0;
      else if (state == W_DATA && wready)
        beat <= beat + 2'd1;
    end
  end

  // Line payload carries no reset; it is only observed after acceptance.
  always_ff @(posedge clk) begin
    if (wr_req && wr_rdy) begin
      line      <= wr_addr[31:4];
      line_data <= wr_data;
    end
  end

  always_comb begin
    state_nxt = state;
    wr_rdy    = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    wr_valid  = 1'b0;
    case (state)
      W_IDLE: begin
        wr_rdy = 1'b1;
        if (wr_req) state_nxt = W_ADDR;
      end
      W_ADDR: begin
        awvalid = 1'b1;
        if (awready) state_nxt = W_DATA;
      end
      W_DATA: begin
        wvalid = 1'b1;
        if (wready && beat == 2'd3) state_nxt = W_RESP;
      end
      W_RESP: begin
        bready = 1'b1;
        if (bvalid) state_nxt = W_DONE;
      end
      W_DONE: begin
        wr_valid  = 1'b1;
        state_nxt = W_IDLE;
      end
      default: state_nxt = W_IDLE;
    endcase
  end

  assign busy    = (state != W_IDLE);
  assign awid    = WR_ID;
  assign awaddr  = {line, 4'b0};
  assign awlen   = LINE_LEN;
  assign awsize  = SIZE_4B;
  assign awburst = BURST_INCR;
  assign wdata   = line_data[{beat, 5'b0} +: 32];
  assign wstrb   = 4'hF;
  assign wlast   = wvalid && (beat == 2'd3);

  // Response status and ID are deliberately ignored; errors complete normally.
  logic unused_ok;
  assign unused_ok = ^{wr_addr[3:0], bid, bresp};

endmodule

// File: rtl/cache_axi_bridge.sv
// Cache line refill / write-back bridge to an AXI master port.
// Define CACHE_AXI_RAW_CHECK_EN to stall reads that hit a line still being written back.
module cache_axi_bridge
  import cache_axi_pkg::*;
#(
  parameter logic [3:0] RD_ID = 4'd0,
  parameter logic [3:0] WR_ID = 4'd1
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         rd_req,
  input  logic [31:0]  rd_addr,
  output logic         rd_rdy,
  output logic         ret_valid,
  output logic [127:0] ret_data,
  input  logic         wr_req,
  input  logic [31:0]  wr_addr,
  input  logic [127:0] wr_data,
  output logic         wr_rdy,
  output logic         wr_valid,
  output logic [3:0]   arid,
  output logic [31:0]  araddr,
  output logic [7:0]   arlen,
  output logic [2:0]   arsize,
  output logic [1:0]   arburst,
  output logic         arvalid,
  input  logic         arready,
  input  logic [3:0]   rid,
  input  logic [31:0]  rdata,
  input  logic [1:0]   rresp,
  input  logic         rlast,
  input  logic         rvalid,
  output logic         rready,
  output logic [3:0]   awid,
  output logic [31:0]  awaddr,
  output logic [7:0]   awlen,
  output logic [2:0]   awsize,
  output logic [1:0]   awburst,
  output logic         awvalid,
  input  logic         awready,
  output logic [31:0]  wdata,
  output logic [3:0]   wstrb,
  output logic         wlast,
  output logic         wvalid,
  input  logic         wready,
  input  logic [3:0]   bid,
  input  logic [1:0]   bresp,
  input  logic         bvalid,
  output logic         bready
);

  rd_state_t   rd_state, rd_state_nxt;
  logic [1:0]  rd_beat;
  logic [27:0] rd_line;
  logic        raw_block;
  logic        wr_busy;
  logic [27:0] wr_line;

  axi_line_writer #(.WR_ID(WR_ID)) writer (
    .clk      (clk),
    .resetn   (resetn),
    .wr_req   (wr_req),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_rdy   (wr_rdy),
    .wr_valid (wr_valid),
    .busy     (wr_busy),
    .line     (wr_line),
    .awid     (awid),
    .awaddr   (awaddr),
    .awlen    (awlen),
    .awsize   (awsize),
    .awburst  (awburst),
    .awvalid  (awvalid),
    .awready  (awready),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .wlast    (wlast),
    .wvalid   (wvalid),
    .wready   (wready),
    .bid      (bid),
    .bresp    (bresp),
    .bvalid   (bvalid),
    .bready   (bready)
  );

`ifdef CACHE_AXI_RAW_CHECK_EN
  // Hold off a refill of a line whose write-back is still in flight.
  assign raw_block = wr_busy && (rd_addr[31:4] == wr_line);
  logic unused_ok;
  assign unused_ok = ^{rd_addr[3:0], rid, rresp};
`else
  assign raw_block = 1'b0;
  logic unused_ok;
  assign unused_ok = ^{rd_addr[3:0], rid, rresp, wr_busy, wr_line};
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_state <= R_IDLE;
      rd_beat  <= 2'd0;
      ret_data <= '0;
    end else begin
      rd_state <= rd_state_nxt;
      if (rd_state == R_IDLE)
        rd_beat <= 2'd0;
      else if (rd_state == R_DATA && rvalid) begin
        ret_data[{rd_beat, 5'b0} +: 32] <= rdata;
        rd_beat <= rd_beat + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rd_req && rd_rdy)
      rd_line <= rd_addr[31:4];
  end

  always_comb begin
    rd_state_nxt = rd_state;
    rd_rdy       = 1'b0;
    arvalid      = 1'b0;
    rready       = 1'b0;
    ret_valid    = 1'b0;
    case (rd_state)
      R_IDLE: begin
        rd_rdy = !raw_block;
        if (rd_req && !raw_block) rd_state_nxt = R_ADDR;
      end
      R_ADDR: begin
        arvalid = 1'b1;
        if (arready) rd_state_nxt = R_DATA;
      end
      R_DATA: begin
        rready = 1'b1;
        if (rvalid && rlast) rd_state_nxt = R_DONE;
      end
      R_DONE: begin
        ret_valid    = 1'b1;
        rd_state_nxt = R_IDLE;
      end
      default: rd_state_nxt = R_IDLE;
    endcase
  end

  assign arid    = RD_ID;
  assign araddr  = {rd_line, 4'b0};
  assign arlen   = LINE_LEN;
  assign arsize  = SIZE_4B;
  assign arburst = BURST_INCR;

endmodule

// File: tb/tb_cache_axi_bridge.sv
// Directed bench for cache_axi_bridge: AXI slave model with one idle cycle
// before R data and before B, plus a line-level scoreboard checked every cycle.
`timescale 1ns/1ps
module tb_cache_axi_bridge;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         rd_req = 1'b0, wr_req = 1'b0;
  logic [31:0]  rd_addr = '0, wr_addr = '0;
  logic [127:0] wr_data = '0;
  logic         rd_rdy, ret_valid, wr_rdy, wr_valid;
  logic [127:0] ret_data;
  logic [3:0]   arid, awid, rid, bid;
  logic [31:0]  araddr, awaddr, rdata, wdata;
  logic [7:0]   arlen, awlen;
  logic [2:0]   arsize, awsize;
  logic [1:0]   arburst, awburst, rresp, bresp;
  logic         arvalid, arready, rlast, rvalid, rready;
  logic         awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]   wstrb;

  cache_axi_bridge #(.RD_ID(4'd0), .WR_ID(4'd1)) dut (
    .clk(clk), .resetn(resetn),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_data(ret_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_rdy(wr_rdy), .wr_valid(wr_valid),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arburst(arburst), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast),
    .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready), .bid(bid), .bresp(bresp), .bvalid(bvalid),
    .bready(bready)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- AXI slave model ----------------
  int          ar_delay = 0;
  bit          wr_toggle = 1'b0;
  logic [31:0] rbeats[4];
  logic [31:0] w_cap[$];
  bit          s_ar_hs, s_r_hs, s_w_hs, s_w_last, s_b_hs;
  int          ar_cnt = 0, r_gap = 0, r_beat = 0, b_gap = 0;
  bit          r_active = 1'b0, b_pend = 1'b0, wtog = 1'b0;

  initial begin
    arready = 0; rvalid = 0; rdata = 0; rlast = 0; rresp = 0; rid = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 0;
    forever begin
      @(negedge clk);
      s_ar_hs  = arvalid && arready;
      s_r_hs   = rvalid && rready;
      s_w_hs   = wvalid && wready;
      s_w_last = wlast;
      s_b_hs   = bvalid && bready;
      if (s_w_hs) w_cap.push_back(wdata);
      @(posedge clk);
      #1;
      if (!resetn) begin
        arready = 0; rvalid = 0; rlast = 0; awready = 0; wready = 0; bvalid = 0;
        ar_cnt = 0; r_gap = 0; r_beat = 0; b_gap = 0;
        r_active = 0; b_pend = 0; wtog = 0;
        continue;
      end
      if (s_r_hs) begin
        r_beat++;
        if (r_beat == 4) r_active = 0;
      end
      if (s_ar_hs) begin
        r_active = 1; r_beat = 0; r_gap = 1;
      end else if (r_active && r_gap > 0) r_gap--;
      rvalid = r_active && (r_gap == 0);
      rdata  = rbeats[r_beat % 4];
      rlast  = rvalid && (r_beat == 3);
      rresp  = 2'($urandom_range(0, 3));
      rid    = 4'($urandom_range(0, 15));
      if (arvalid) begin
        arready = (ar_cnt >= ar_delay);
        ar_cnt++;
      end else begin
        arready = 0;
        ar_cnt = 0;
      end
      awready = awvalid;
      if (wr_toggle) begin
        wtog = !wtog;
        wready = wtog;
      end else wready = 1;
      if (s_b_hs) bvalid = 0;
      if (s_w_hs && s_w_last) begin
        b_pend = 1; b_gap = 1;
      end else if (b_pend) begin
        if (b_gap > 0) b_gap--;
        if (b_gap == 0) begin
          bvalid = 1; b_pend = 0;
        end
      end
      bresp = 2'($urandom_range(0, 3));
      bid   = 4'($urandom_range(0, 15));
    end
  end

  // ---------------- Line-level scoreboard ----------------
  int           cyc = 0;
  bit           rd_idle_exp = 1, wr_idle_exp = 1;
  bit           exp_rd_rdy, exp_wr_rdy;
  logic [31:0]  rd_line_exp = '0, wr_line_exp = '0;
  logic [31:0]  wr_words_exp[4];
  logic [127:0] line_exp_last = '0, exp_line;
  int           rd_acc_cyc = 0, wr_acc_cyc = 0, rd_done_cnt = 0, wr_done_cnt = 0;
  int           w_k = 0, wlast_cnt = 0, ar_hs_cnt = 0, aw_hs_cnt = 0;
  int           rd_lat_seen = 0, wr_lat_seen = 0, exp_rd_lat = 7, exp_wr_lat = 8;
  int           last_wr_done_cyc = 0, rd_raise_cyc = 0;
  bit           b_seen = 0;
  logic [31:0]  ar_seen_addr = '0, aw_seen_addr = '0;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (!resetn) begin
      check("reset_ctrl_outputs",
            {rd_rdy, wr_rdy, ret_valid, wr_valid, arvalid, rready, awvalid, wvalid, wlast, bready},
            10'b11_0000_0000);
      check("reset_ret_data", ret_data, 128'b0);
      rd_idle_exp = 1; wr_idle_exp = 1; line_exp_last = '0;
      continue;
    end
    exp_wr_rdy = wr_idle_exp;
`ifdef CACHE_AXI_RAW_CHECK_EN
    exp_rd_rdy = rd_idle_exp && !(!wr_idle_exp && rd_addr[31:4] == wr_line_exp[31:4]);
`else
    exp_rd_rdy = rd_idle_exp;
`endif
    check("rd_rdy", rd_rdy, exp_rd_rdy);
    check("wr_rdy", wr_rdy, exp_wr_rdy);

    if (arvalid) begin
      check("araddr", araddr, rd_line_exp);
      check("ar_ctrl", {arid, arlen, arsize, arburst}, {4'd0, 8'd3, 3'd2, 2'b01});
      ar_seen_addr = araddr;
      if (arready) ar_hs_cnt++;
    end
    if (rvalid) check("rready_during_data", rready, 1'b1);
    if (awvalid) begin
      check("awaddr", awaddr, wr_line_exp);
      check("aw_ctrl", {awid, awlen, awsize, awburst}, {4'd1, 8'd3, 3'd2, 2'b01});
      aw_seen_addr = awaddr;
      if (awready) aw_hs_cnt++;
    end
    if (wvalid) begin
      check("wdata", wdata, wr_words_exp[w_k % 4]);
      check("wlast", wlast, w_k == 3);
      check("wstrb", wstrb, 4'hF);
      if (wready) begin
        if (wlast) wlast_cnt++;
        w_k++;
      end
    end else check("wlast_without_wvalid", wlast, 1'b0);
    if (bvalid && bready) b_seen = 1;

    exp_line = {rbeats[3], rbeats[2], rbeats[1], rbeats[0]};
    if (rd_idle_exp) begin
      check("ret_valid_while_idle", ret_valid, 1'b0);
      check("ret_data_hold", ret_data, line_exp_last);
    end else if (ret_valid) begin
      check("ret_data", ret_data, exp_line);
      check("ar_handshakes", ar_hs_cnt, 1);
      rd_lat_seen = cyc - rd_acc_cyc;
      if (exp_rd_lat >= 0) check("rd_latency", rd_lat_seen, exp_rd_lat);
      line_exp_last = exp_line;
      rd_idle_exp = 1;
      rd_done_cnt++;
    end

    if (wr_idle_exp) check("wr_valid_while_idle", wr_valid, 1'b0);
    else if (wr_valid) begin
      check("w_beat_count", w_k, 4);
      check("wlast_count", wlast_cnt, 1);
      check("b_before_wr_valid", b_seen, 1'b1);
      check("aw_handshakes", aw_hs_cnt, 1);
      wr_lat_seen = cyc - wr_acc_cyc;
      if (exp_wr_lat >= 0) check("wr_latency", wr_lat_seen, exp_wr_lat);
      wr_idle_exp = 1;
      wr_done_cnt++;
      last_wr_done_cyc = cyc;
    end

    if (rd_req && exp_rd_rdy) begin
      rd_idle_exp = 0;
      rd_line_exp = {rd_addr[31:4], 4'b0};
      rd_acc_cyc = cyc;
      ar_hs_cnt = 0;
    end
    if (wr_req && exp_wr_rdy) begin
      wr_idle_exp = 0;
      wr_line_exp = {wr_addr[31:4], 4'b0};
      for (int i = 0; i < 4; i++) wr_words_exp[i] = wr_data[32*i +: 32];
      wr_acc_cyc = cyc;
      w_k = 0; wlast_cnt = 0; b_seen = 0; aw_hs_cnt = 0;
    end
  end

  // ---------------- Stimulus ----------------
  task automatic issue(input bit do_rd, input logic [31:0] ra,
                       input bit do_wr, input logic [31:0] wa, input logic [127:0] wd);
    bit rd_pend, wr_pend;
    int n;
    rd_pend = do_rd; wr_pend = do_wr; n = 0;
    @(posedge clk);
    #1;
    rd_req = do_rd; rd_addr = ra; wr_req = do_wr; wr_addr = wa; wr_data = wd;
    rd_raise_cyc = cyc + 1;
    while ((rd_pend || wr_pend) && n < 100) begin
      @(negedge clk);
      if (rd_req && rd_rdy) rd_pend = 0;
      if (wr_req && wr_rdy) wr_pend = 0;
      @(posedge clk);
      #1;
      if (!rd_pend) rd_req = 0;
      if (!wr_pend) wr_req = 0;
      n++;
    end
    check("accept_timeout", {rd_pend, wr_pend}, 2'b00);
    rd_req = 0; wr_req = 0;
  endtask

  task automatic wait_done(input int rd_target, input int wr_target);
    int n;
    n = 0;
    while ((rd_done_cnt < rd_target || wr_done_cnt < wr_target) && n < 200) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    check("done_timeout", {rd_done_cnt >= rd_target, wr_done_cnt >= wr_target}, 2'b11);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int rd_base, wr_base, n;
    rbeats[0] = '0; rbeats[1] = '0; rbeats[2] = '0; rbeats[3] = '0;
    repeat (3) @(negedge clk);
    #2 resetn = 1;
    repeat (2) @(negedge clk);

    // Line refill from an unaligned address
    rbeats[0] = 32'h11; rbeats[1] = 32'h22; rbeats[2] = 32'h33; rbeats[3] = 32'h44;
    exp_rd_lat = 7; exp_wr_lat = 8;
    issue(1, 32'h1FC0_0014, 0, '0, '0);
    wait_done(rd_done_cnt + 1, wr_done_cnt);
    check("t1_araddr", ar_seen_addr, 32'h1FC0_0010);
    check("t1_ret_data", ret_data, 128'h00000044_00000033_00000022_00000011);
    check("t1_rd_latency", rd_lat_seen, 7);

    // Line write-back
    w_cap.delete();
    issue(0, '0, 1, 32'h0000_1238, {32'hD3D3_D3D3, 32'hC2C2_C2C2, 32'hB1B1_B1B1, 32'hA0A0_A0A0});
    wait_done(rd_done_cnt, wr_done_cnt + 1);
    check("t2_awaddr", aw_seen_addr, 32'h0000_1230);
    check("t2_wr_latency", wr_lat_seen, 8);
    check("t2_w_count", w_cap.size(), 4);
    if (w_cap.size() == 4)
      check("t2_w_beats", {w_cap[3], w_cap[2], w_cap[1], w_cap[0]},
            {32'hD3D3_D3D3, 32'hC2C2_C2C2, 32'hB1B1_B1B1, 32'hA0A0_A0A0});

    // Backpressure: slow arready, toggling wready
    ar_delay = 3; wr_toggle = 1; exp_rd_lat = 10; exp_wr_lat = -1;
    rbeats[0] = 32'hCAFE_0000; rbeats[1] = 32'hCAFE_0001;
    rbeats[2] = 32'hCAFE_0002; rbeats[3] = 32'hCAFE_0003;
    w_cap.delete();
    rd_base = rd_done_cnt; wr_base = wr_done_cnt;
    issue(1, 32'h2000_0048, 1, 32'h3000_005C, {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000});
    wait_done(rd_base + 1, wr_base + 1);
    check("t3_rd_latency", rd_lat_seen, 10);
    check("t3_araddr", ar_seen_addr, 32'h2000_0040);
    if (w_cap.size() == 4)
      check("t3_w_beats", {w_cap[3], w_cap[2], w_cap[1], w_cap[0]},
            {32'h4444_0003, 32'h3333_0002, 32'h2222_0001, 32'h1111_0000});
    else check("t3_w_count", w_cap.size(), 4);
    ar_delay = 0; wr_toggle = 0; exp_rd_lat = 7; exp_wr_lat = 8;

    // Concurrent refill and write-back to different lines
    rbeats[0] = 32'h0BAD_F00D; rbeats[1] = 32'h1234_5678;
    rbeats[2] = 32'h9ABC_DEF0; rbeats[3] = 32'h0F0F_F0F0;
    rd_base = rd_done_cnt; wr_base = wr_done_cnt;
    issue(1, 32'h0000_1004, 1, 32'h0000_2008, {32'hDDDD_0000, 32'hCCCC_0000, 32'hBBBB_0000, 32'hAAAA_0000});
    wait_done(rd_base + 1, wr_base + 1);
    check("t4_ret_data", ret_data, 128'h0F0FF0F0_9ABCDEF0_12345678_0BADF00D);
    check("t4_wr_latency", wr_lat_seen, 8);

    // Read of a line whose write-back is still pending
    rd_base = rd_done_cnt; wr_base = wr_done_cnt;
    issue(0, '0, 1, 32'h0000_0080, {32'h8888_0003, 32'h8888_0002, 32'h8888_0001, 32'h8888_0000});
    issue(1, 32'h0000_0084, 0, '0, '0);
    wait_done(rd_base + 1, wr_base + 1);
`ifdef CACHE_AXI_RAW_CHECK_EN
    check("t5_raw_accept_after_wr_valid", rd_acc_cyc, last_wr_done_cyc + 1);
`else
    check("t5_accept_immediate", rd_acc_cyc, rd_raise_cyc);
`endif

    // Reset while beat 2 of a refill is on the bus
    rbeats[0] = 32'hDEAD_0000; rbeats[1] = 32'hDEAD_0001;
    rbeats[2] = 32'hDEAD_0002; rbeats[3] = 32'hDEAD_0003;
    rd_base = rd_done_cnt;
    issue(1, 32'h0000_0500, 0, '0, '0);
    n = 0;
    while (!(rvalid && r_beat == 2) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("t6_reached_beat2", r_beat, 2);
    #2 resetn = 0;
    #1 check("t6_reset_ret_data", ret_data, 128'b0);
    check("t6_reset_rdy", {rd_rdy, wr_rdy, rready, ret_valid}, 4'b1100);
    repeat (3) @(negedge clk);
    #2 resetn = 1;
    check("t6_no_done_after_reset", rd_done_cnt, rd_base);
    rbeats[0] = 32'h5555_0000; rbeats[1] = 32'h5555_1111;
    rbeats[2] = 32'h5555_2222; rbeats[3] = 32'h5555_3333;
    issue(1, 32'h0000_0ABC, 0, '0, '0);
    wait_done(rd_base + 1, wr_done_cnt);
    check("t6_refill_after_reset", ret_data, 128'h55553333_55552222_55551111_55550000);
    check("t6_araddr", ar_seen_addr, 32'h0000_0AB0);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
